// File: rtl/sqrt_formula_result_buffer.sv
// sqrt_formula_result_buffer
//
// Flow-control shell around sqrt_formula_distributor. Accepted upstream
// triples become single arg_vld pulses to the distributor. Every result pulse
// from the distributor is captured in a FIFO and drained over a valid/ready
// port, so a stalling consumer never loses results. Free FIFO slots are
// reserved for tasks still inside the distributor (credit scheme), and the
// number of tasks in flight never exceeds the distributor's worker count.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. On the upstream side, in_rdy depends only
// on registers. On the downstream side, out_vld/out_res depend only on
// registers, and out_res holds while out_vld is 1 and out_rdy is 0.
//
// Ports
//   clk       clock, all flops on the rising edge
//   rst       asynchronous reset, active-low
//   in_vld    upstream triple valid (a/b/c go straight to the distributor)
//   in_rdy    upstream may transfer this cycle
//   arg_vld   start pulse to the distributor (in_vld & in_rdy)
//   res_vld   distributor result valid (single-cycle pulse)
//   res       distributor result value
//   out_vld   FIFO head valid
//   out_rdy   consumer accepts the head
//   out_res   FIFO head value (first-word fall-through)
//   inflight  tasks issued whose result has not come back yet
//   count     results held in the FIFO
//   err       sticky protocol error (stray result, or result into a full FIFO)

module sqrt_formula_result_buffer #(
    parameter int DEPTH        = 64,
    parameter int MAX_INFLIGHT = 50,
    parameter int W            = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_vld,
    output logic                              in_rdy,
    output logic                              arg_vld,
    input  logic                              res_vld,
    input  logic [W-1:0]                      res,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [W-1:0]                      out_res,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    // Wide enough to hold inflight + count without overflow.
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    logic [IW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic          err_q,      err_d;

    logic [W-1:0]  mem_q [DEPTH];

    logic [SW-1:0] occupancy;
    logic          accept;
    logic          ret;
    logic          full;
    logic          pop;
    logic          wr;

    always_comb begin
        occupancy = SW'(inflight_q) + SW'(count_q);
        // Credit check: every task in flight already owns a FIFO slot.
        in_rdy    = (inflight_q < IW'(MAX_INFLIGHT)) && (occupancy < SW'(DEPTH));
        accept    = in_vld & in_rdy;
        arg_vld   = accept;

        // A stray result (nothing in flight) must not underflow the counter.
        ret       = res_vld & (inflight_q != '0);

        full      = (count_q == CW'(DEPTH));
        out_vld   = (count_q != '0);
        pop       = out_vld & out_rdy;
        // When full, a same-cycle pop frees the slot the write needs.
        wr        = res_vld & (~full | pop);
    end

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;

        unique case ({accept, ret})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        unique case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        if (res_vld && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
        if (res_vld && full && !pop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= res;
        end
    end

    assign out_res  = mem_q[rd_ptr_q];
    assign inflight = inflight_q;
    assign count    = count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sqrt_formula_result_buffer.sv
module tb_sqrt_formula_result_buffer;

  localparam int DEPTH = 8;
  localparam int MAXI  = 6;
  localparam int W     = 32;
  localparam int IW    = $clog2(MAXI + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_vld;
  logic          in_rdy;
  logic          arg_vld;
  logic          res_vld;
  logic [W-1:0]  res;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  out_res;
  logic [IW-1:0] inflight;
  logic [CW-1:0] count;
  logic          err;

  sqrt_formula_result_buffer #(
    .DEPTH(DEPTH),
    .MAX_INFLIGHT(MAXI),
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .arg_vld(arg_vld),
    .res_vld(res_vld),
    .res(res),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_res(out_res),
    .inflight(inflight),
    .count(count),
    .err(err)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int           due;
    logic [W-1:0] val;
  } ret_t;

  ret_t         sched_q[$];   // fake distributor: results waiting to return
  logic [W-1:0] exp_q[$];     // results the FIFO should hold, head first
  int           m_infl;
  bit           m_err;

  int n_vec;
  int n_miss;
  int cyc;
  int lat;
  bit drv_in_vld;
  bit drv_out_rdy;
  bit inject;

  bit last_arg;
  bit last_rdy;
  bit last_res;
  bit last_pop;
  int max_infl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check and advance model at negedge.
  task automatic cycle();
    bit   m_rdy;
    bit   acc;
    bit   pop;
    bit   full;
    ret_t r;
    res_vld = 1'b0;
    res     = '0;
    if (inject) begin
      res_vld = 1'b1;
      res     = $urandom;
      inject  = 1'b0;
    end else if (sched_q.size() != 0 && sched_q[0].due <= cyc) begin
      res_vld = 1'b1;
      res     = sched_q[0].val;
      void'(sched_q.pop_front());
    end
    in_vld  = drv_in_vld;
    out_rdy = drv_out_rdy;
    @(negedge clk);

    m_rdy = (m_infl < MAXI) && (m_infl + exp_q.size() < DEPTH);
    chk("in_rdy", in_rdy, m_rdy);
    chk("arg_vld", arg_vld, in_vld && m_rdy);
    chk("out_vld", out_vld, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_res", out_res, exp_q[0]);
    chk("inflight", inflight, m_infl);
    chk("count", count, exp_q.size());
    chk("err", err, m_err);

    last_arg = arg_vld;
    last_rdy = in_rdy;
    last_res = res_vld;
    last_pop = out_vld & out_rdy;
    if (int'(inflight) > max_infl) max_infl = int'(inflight);

    acc  = in_vld && m_rdy;
    pop  = out_rdy && exp_q.size() != 0;
    full = exp_q.size() == DEPTH;
    if (res_vld) begin
      if (m_infl == 0) m_err = 1'b1;
      else m_infl--;
    end
    if (acc) begin
      m_infl++;
      r.due = cyc + lat;
      r.val = $urandom;
      sched_q.push_back(r);
    end
    if (pop) void'(exp_q.pop_front());
    if (res_vld) begin
      if (full && !pop) m_err = 1'b1;
      else exp_q.push_back(res);
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted in the middle of a cycle.
  task automatic do_reset();
    #2;
    in_vld  = 1'b1;
    res_vld = 1'b0;
    rst     = 1'b0;
    #1;
    exp_q.delete();
    sched_q.delete();
    m_infl = 0;
    m_err  = 1'b0;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_arg_vld", arg_vld, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst    = 1'b1;
    in_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_acc;
    int n_pop;
    int first_drop;
    int first_ret;

    n_vec = 0; n_miss = 0; cyc = 0; lat = 4;
    rst = 1'b0; in_vld = 1'b0; res_vld = 1'b0; res = '0; out_rdy = 1'b0;
    drv_in_vld = 1'b0; drv_out_rdy = 1'b0; inject = 1'b0;
    m_infl = 0; m_err = 1'b0; max_infl = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Streaming: 10 requests, latency 4, consumer always ready.
    lat = 4; drv_out_rdy = 1'b1; max_infl = 0; n_acc = 0; n_pop = 0;
    for (int i = 0; i < 30; i++) begin
      drv_in_vld = (i < 10);
      cycle();
      if (last_arg) n_acc++;
      if (last_pop) n_pop++;
    end
    chk("stream_accepts", n_acc, 10);
    chk("stream_pops", n_pop, 10);
    chk("stream_max_inflight", max_infl, 4);

    // Worker limit: long latency, requests held.
    lat = 20; drv_out_rdy = 1'b1; drv_in_vld = 1'b1;
    n_acc = 0; first_drop = -1; first_ret = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (first_drop < 0) begin
        if (!last_rdy) begin
          first_drop = i;
          chk("accepts_before_drop", n_acc, MAXI);
        end else if (last_arg) begin
          n_acc++;
        end
      end
      if (first_ret >= 0 && i == first_ret + 1) chk("rdy_after_first_ret", last_rdy, 1);
      if (last_res && first_ret < 0) first_ret = i;
    end
    chk("drop_cycle", first_drop, MAXI);
    chk("first_ret_cycle", first_ret, 20);
    drv_in_vld = 1'b0;
    for (int i = 0; i < 30; i++) cycle();

    // Credit stall: consumer stalled, FIFO credit is the limit.
    lat = 3; drv_out_rdy = 1'b0; drv_in_vld = 1'b1; n_acc = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (last_arg) n_acc++;
    end
    chk("credit_accepts", n_acc, DEPTH);
    chk("credit_count", count, DEPTH);
    chk("credit_in_rdy", in_rdy, 0);
    chk("credit_inflight", inflight, 0);
    drv_out_rdy = 1'b1;
    cycle();
    drv_out_rdy = 1'b0;
    cycle();
    chk("rdy_after_pop", last_rdy, 1);
    for (int i = 0; i < 6; i++) cycle();
    chk("refill_count", count, DEPTH);

    // Random traffic, legal distributor behaviour throughout.
    lat = 5;
    for (int i = 0; i < 150; i++) begin
      drv_in_vld  = ($urandom_range(0, 1) == 1);
      drv_out_rdy = ($urandom_range(0, 2) == 0);
      cycle();
    end
    drv_in_vld = 1'b0; drv_out_rdy = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    chk("random_drained", count, 0);

    // Errors: fill, then stray results with and without a pop.
    lat = 3; drv_in_vld = 1'b1; drv_out_rdy = 1'b0;
    for (int i = 0; i < 25; i++) cycle();
    drv_in_vld = 1'b0;
    inject = 1'b1; drv_out_rdy = 1'b1;
    cycle();
    chk("full_pop_write_count", count, DEPTH);
    chk("stray_err", err, 1);
    inject = 1'b1; drv_out_rdy = 1'b0;
    cycle();
    chk("full_drop_count", count, DEPTH);
    drv_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("err_sticky", err, 1);
    do_reset();

    // Clean traffic after reset.
    lat = 2; drv_out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drv_in_vld = (i < 3);
      cycle();
    end
    chk("post_reset_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
